// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: branch select, flag select, flag bit positions.
// Pure declarations; no latency and no stall behaviour.
package branch_pkg;

    typedef enum logic [1:0] {
        BS_SEQ     = 2'b00,
        BS_COND    = 2'b01,
        BS_JMP     = 2'b10,
        BS_CALLRET = 2'b11
    } bs_e;

    typedef enum logic [1:0] {
        FSEL_Z = 2'b00,
        FSEL_C = 2'b01,
        FSEL_N = 2'b10,
        FSEL_V = 2'b11
    } fsel_e;

    // Flag register layout {N,C,V,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/branch_ras.sv
// Circular return-address stack; a push when full silently replaces the oldest entry.
// Push/pop take effect on the next edge, top is a read of stored state; the caller gates push/pop with its stall.
module branch_ras
    import branch_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [PC_W-1:0]              i_dat,
    output logic [PC_W-1:0]              o_top,
    output logic [$clog2(RAS_DEPTH):0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PC_W-1:0]  r_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_cnt;
    logic [PTR_W-1:0] w_top_idx;

    assign w_top_idx = r_ptr - PTR_W'(1);
    assign o_top     = r_mem[w_top_idx];
    assign o_count   = r_cnt;
    assign o_full    = (r_cnt == (PTR_W+1)'(RAS_DEPTH));
    assign o_empty   = (r_cnt == '0);

    // Entry storage needs no reset; only the pointer and count define validity.
    always_ff @(posedge clk) begin
        if (i_push)
            r_mem[r_ptr] <= i_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!o_full)
                r_cnt <= r_cnt + (PTR_W+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/branch_control.sv
// Program-counter sequencer with conditional branches, jumps and call/return via a return-address stack.
// All outputs registered, one cycle after the qualifying edge; en=0 stalls PC and stack, flags still load.
module branch_control
    import branch_pkg::*;
#(
    parameter int PC_W      = 8,
    parameter int OFS_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       bs,
    input  logic [2:0]       cond,
    input  logic             ret,
    input  logic [OFS_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    input  logic             flag_we,
    input  logic [3:0]       flags_in,
    output logic [PC_W-1:0]  pc,
    output logic [3:0]       flags_q,
    output logic             flush,
    output logic             ras_ovf,
    output logic             ras_udf
);
    logic [PC_W-1:0]            r_pc;
    logic [3:0]                 r_flags;
    logic                       r_flush;
    logic                       r_ovf;
    logic                       r_udf;

    logic [3:0]                 w_flags_src;
    logic                       w_sel_flag;
    logic                       w_taken;
    logic [PC_W-1:0]            w_ofs_ext;
    logic [PC_W-1:0]            w_pc_nxt;
    logic                       w_redirect;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_ovf_set;
    logic                       w_udf_set;
    logic [PC_W-1:0]            w_ras_top;
    logic [$clog2(RAS_DEPTH):0] w_ras_count;
    logic                       w_ras_full;
    logic                       w_ras_empty;
    logic                       w_unused_cnt;

    // A flag write in the same cycle is forwarded so compare-and-branch pairs need no bubble.
    assign w_flags_src  = flag_we ? flags_in : r_flags;
    assign w_ofs_ext    = PC_W'($signed(offset));
    assign w_taken      = w_sel_flag ^ cond[0];
    assign w_unused_cnt = ^w_ras_count;

    always_comb begin
        w_sel_flag = w_flags_src[FLAG_Z];
        unique case (fsel_e'(cond[2:1]))
            FSEL_Z: w_sel_flag = w_flags_src[FLAG_Z];
            FSEL_C: w_sel_flag = w_flags_src[FLAG_C];
            FSEL_N: w_sel_flag = w_flags_src[FLAG_N];
            FSEL_V: w_sel_flag = w_flags_src[FLAG_V];
        endcase
    end

    always_comb begin
        w_pc_nxt   = r_pc + PC_W'(1);
        w_redirect = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ovf_set  = 1'b0;
        w_udf_set  = 1'b0;
        unique case (bs_e'(bs))
            BS_SEQ: ;
            BS_COND: begin
                if (w_taken) begin
                    w_pc_nxt   = r_pc + w_ofs_ext;
                    w_redirect = 1'b1;
                end
            end
            BS_JMP: begin
                w_pc_nxt   = target;
                w_redirect = 1'b1;
            end
            BS_CALLRET: begin
                w_redirect = 1'b1;
                if (ret) begin
                    // Underflow still redirects (to pc+1) so the pipeline is flushed consistently.
                    if (w_ras_empty) begin
                        w_udf_set = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_pc_nxt = w_ras_top;
                    end
                end else begin
                    w_push    = 1'b1;
                    w_ovf_set = w_ras_full;
                    w_pc_nxt  = target;
                end
            end
        endcase
    end

    branch_ras #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (en & w_push),
        .i_pop   (en & w_pop),
        .i_dat   (r_pc + PC_W'(1)),
        .o_top   (w_ras_top),
        .o_count (w_ras_count),
        .o_full  (w_ras_full),
        .o_empty (w_ras_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_flags <= '0;
            r_flush <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (en)
                r_pc <= w_pc_nxt;
            if (flag_we)
                r_flags <= flags_in;
            r_flush <= en & w_redirect;
            if (en & w_ovf_set)
                r_ovf <= 1'b1;
            if (en & w_udf_set)
                r_udf <= 1'b1;
        end
    end

    assign pc      = r_pc;
    assign flags_q = r_flags;
    assign flush   = r_flush;
    assign ras_ovf = r_ovf;
    assign ras_udf = r_udf;

endmodule

// File: tb/tb_branch_control.sv
// Scoreboard bench for branch_control: a behavioural model queues the expected state per cycle,
// compared one edge later; directed points also check fixed constants.
module tb_branch_control;
    localparam int PC_W      = 8;
    localparam int OFS_W     = 8;
    localparam int RAS_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             en;
    logic [1:0]       bs;
    logic [2:0]       cond;
    logic             ret;
    logic [OFS_W-1:0] offset;
    logic [PC_W-1:0]  target;
    logic             flag_we;
    logic [3:0]       flags_in;
    logic [PC_W-1:0]  pc;
    logic [3:0]       flags_q;
    logic             flush;
    logic             ras_ovf;
    logic             ras_udf;

    branch_control #(
        .PC_W      (PC_W),
        .OFS_W     (OFS_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bs       (bs),
        .cond     (cond),
        .ret      (ret),
        .offset   (offset),
        .target   (target),
        .flag_we  (flag_we),
        .flags_in (flags_in),
        .pc       (pc),
        .flags_q  (flags_q),
        .flush    (flush),
        .ras_ovf  (ras_ovf),
        .ras_udf  (ras_udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pc;
        logic       flush;
        logic [3:0] flags;
        logic       ovf;
        logic       udf;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] m_pc;
    logic [3:0] m_flags;
    logic       m_ovf;
    logic       m_udf;
    logic [7:0] m_stk[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = '0;
        m_flags = '0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_stk.delete();
        sb_q.delete();
    endtask

    // Drive one cycle, predict its outcome, then check the DUT after the edge.
    task automatic cyc(input logic i_en, input logic [1:0] i_bs, input logic [2:0] i_cond,
                       input logic i_ret, input logic [7:0] i_ofs, input logic [7:0] i_tgt,
                       input logic i_fwe, input logic [3:0] i_fin);
        logic [3:0] fs;
        logic       sel;
        logic       redir;
        logic [7:0] npc;
        exp_t       e;
        en = i_en; bs = i_bs; cond = i_cond; ret = i_ret;
        offset = i_ofs; target = i_tgt; flag_we = i_fwe; flags_in = i_fin;

        fs = i_fwe ? i_fin : m_flags;
        case (i_cond[2:1])
            2'b00:   sel = fs[0];
            2'b01:   sel = fs[2];
            2'b10:   sel = fs[3];
            default: sel = fs[1];
        endcase
        redir = 1'b0;
        npc   = i_en ? m_pc + 8'd1 : m_pc;
        if (i_en) begin
            case (i_bs)
                2'b01: if (sel ^ i_cond[0]) begin npc = m_pc + i_ofs; redir = 1'b1; end
                2'b10: begin npc = i_tgt; redir = 1'b1; end
                2'b11: begin
                    redir = 1'b1;
                    if (i_ret) begin
                        if (m_stk.size() == 0) m_udf = 1'b1;
                        else npc = m_stk.pop_back();
                    end else begin
                        m_stk.push_back(m_pc + 8'd1);
                        if (m_stk.size() > RAS_DEPTH) begin
                            void'(m_stk.pop_front());
                            m_ovf = 1'b1;
                        end
                        npc = i_tgt;
                    end
                end
                default: ;
            endcase
        end
        if (i_fwe) m_flags = i_fin;
        m_pc = npc;
        sb_q.push_back('{pc: npc, flush: redir, flags: m_flags, ovf: m_ovf, udf: m_udf});

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("pc",      32'(pc),      32'(e.pc));
        chk("flush",   32'(flush),   32'(e.flush));
        chk("flags_q", 32'(flags_q), 32'(e.flags));
        chk("ras_ovf", 32'(ras_ovf), 32'(e.ovf));
        chk("ras_udf", 32'(ras_udf), 32'(e.udf));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},    32'(pc),      32'h0);
        chk({tag, "_flags"}, 32'(flags_q), 32'h0);
        chk({tag, "_flush"}, 32'(flush),   32'h0);
        chk({tag, "_ovf"},   32'(ras_ovf), 32'h0);
        chk({tag, "_udf"},   32'(ras_udf), 32'h0);
    endtask

    initial begin
        en = 0; bs = 0; cond = 0; ret = 0; offset = 0; target = 0; flag_we = 0; flags_in = 0;
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_state("rst");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Sequential wrap from FE
        cyc(1, 2'b10, 3'b000, 0, 8'h00, 8'hFE, 0, 4'h0);
        cyc(1, 2'b00, 3'b000, 0, 8'h00, 8'h00, 0, 4'h0); chk("seq_ff", 32'(pc), 32'hFF);
        cyc(1, 2'b00, 3'b000, 0, 8'h00, 8'h00, 0, 4'h0); chk("seq_wrap", 32'(pc), 32'h00);
        for (int i = 0; i < 3; i++) cyc(1, 2'b00, 3'b000, 0, 8'h00, 8'h00, 0, 4'h0);
        chk("seq_03", 32'(pc), 32'h03);

        // Conditional relative branch on Z, both polarities
        cyc(1, 2'b10, 3'b000, 0, 8'h00, 8'h10, 0, 4'h0);
        cyc(0, 2'b00, 3'b000, 0, 8'h00, 8'h00, 1, 4'b0001);
        cyc(1, 2'b01, 3'b000, 0, 8'hFD, 8'h00, 0, 4'h0);
        chk("br_taken_pc", 32'(pc), 32'h0D); chk("br_taken_flush", 32'(flush), 32'h1);
        cyc(1, 2'b10, 3'b000, 0, 8'h00, 8'h10, 0, 4'h0);
        cyc(1, 2'b01, 3'b001, 0, 8'hFD, 8'h00, 0, 4'h0);
        chk("br_nt_pc", 32'(pc), 32'h11); chk("br_nt_flush", 32'(flush), 32'h0);

        // Forwarded flag write decides the branch
        cyc(1, 2'b10, 3'b000, 0, 8'h00, 8'h20, 0, 4'h0);
        cyc(1, 2'b01, 3'b000, 0, 8'hFD, 8'h00, 1, 4'b0000);
        chk("fwd_pc", 32'(pc), 32'h21); chk("fwd_flags", 32'(flags_q), 32'h0);

        // Five calls overflow a depth-4 stack, then drain and underflow
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 2'b10, 3'b000, 0, 8'h00, 8'(i), 0, 4'h0);
            cyc(1, 2'b11, 3'b000, 0, 8'h00, 8'h80, 0, 4'h0);
        end
        chk("call_ovf", 32'(ras_ovf), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2'b11, 3'b000, 1, 8'h00, 8'h00, 0, 4'h0);
            chk("ret_pc", 32'(pc), 32'(6 - i));
        end
        cyc(1, 2'b11, 3'b000, 1, 8'h00, 8'h00, 0, 4'h0);
        chk("udf_pc", 32'(pc), 32'h04); chk("udf_flag", 32'(ras_udf), 32'h1);
        chk("udf_flush", 32'(flush), 32'h1);

        // Stall ignores the jump
        cyc(0, 2'b10, 3'b000, 0, 8'h00, 8'h55, 0, 4'h0);
        chk("stall_pc", 32'(pc), 32'h04); chk("stall_flush", 32'(flush), 32'h0);

        // Reset asserted in the middle of a call cycle
        cyc(1, 2'b11, 3'b000, 0, 8'h00, 8'h40, 0, 4'h0);
        en = 1; bs = 2'b11; ret = 0; target = 8'h80;
        #3 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_state("midrst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1, 2'b11, 3'b000, 1, 8'h00, 8'h00, 0, 4'h0);
        chk("post_rst_udf", 32'(ras_udf), 32'h1);

        // Random mix over all flag selects and branch kinds
        for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
